// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared types and funct3 codes for the data-memory responder
package Pipe_Buf_Reg_PKG;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte enables, store replication, load extension and alignment check (DMEM_MISALIGN_TRAP_EN)
module dmem_lane_align
    import Pipe_Buf_Reg_PKG::*;
(
    input  logic        we,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] word_rd,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        err
);

    logic        illegal;
    logic        misalign;
    logic [1:0]  lane;
    logic [31:0] shifted;

    // Decode the access: legality, effective lane, write enables and the extended load result.
    always_comb begin
        illegal   = 1'b0;
        misalign  = 1'b0;
        lane      = addr_lo;
        byte_en   = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = 32'h0;
        shifted   = 32'h0;

        if (we)
            illegal = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
        else
            illegal = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W ||
                        funct3 == F3_BU || funct3 == F3_HU);

        // Halfword accesses ignore addr[0]; word accesses ignore addr[1:0].
        if (funct3 == F3_H || funct3 == F3_HU) begin
`ifdef DMEM_MISALIGN_TRAP_EN
            misalign = addr_lo[0];
`endif
            lane = {addr_lo[1], 1'b0};
        end else if (funct3 == F3_W) begin
`ifdef DMEM_MISALIGN_TRAP_EN
            misalign = (addr_lo != 2'b00);
`endif
            lane = 2'b00;
        end

        err = illegal || misalign;

        if (we && !err) begin
            case (funct3)
                F3_B: begin
                    byte_en   = 4'b0001 << lane;
                    wdata_rep = {4{wdata[7:0]}};
                end
                F3_H: begin
                    byte_en   = 4'b0011 << lane;
                    wdata_rep = {2{wdata[15:0]}};
                end
                default: begin
                    byte_en   = 4'b1111;
                    wdata_rep = wdata;
                end
            endcase
        end

        shifted = word_rd >> {lane, 3'b000};
        if (!we && !err) begin
            case (funct3)
                F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
                F3_BU:   rdata_ext = {24'h0, shifted[7:0]};
                F3_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
                F3_HU:   rdata_ext = {16'h0, shifted[15:0]};
                default: rdata_ext = word_rd;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle RV32I data-memory responder (DMEM_MISALIGN_TRAP_EN selects misalignment trapping)
module dmem_responder
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic                  busy
);

    localparam int WORDS = 1 << (DM_ADDRESS - 2);

    dmem_state_e state, next_state;

    logic [3:0]            cnt;
    logic                  we_q;
    logic [DM_ADDRESS-1:0] addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [2:0]            funct3_q;
    logic [31:0]           mem [WORDS];

    logic                  accept;
    logic                  commit;
    logic [DM_ADDRESS-3:0] word_idx;
    logic [31:0]           word_rd;
    logic [3:0]            byte_en;
    logic [31:0]           wdata_rep;
    logic [31:0]           rdata_ext;
    logic                  lane_err;

    assign accept   = (state == IDLE) && req_valid;
    assign commit   = (state == WAIT) && (cnt == 4'd0);
    assign word_idx = addr_q[DM_ADDRESS-1:2];
    assign word_rd  = mem[word_idx];

    dmem_lane_align u_lane_align (
        .we        (we_q),
        .addr_lo   (addr_q[1:0]),
        .funct3    (funct3_q),
        .wdata     (wdata_q),
        .word_rd   (word_rd),
        .byte_en   (byte_en),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext),
        .err       (lane_err)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state and handshake outputs.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid)
                    next_state = WAIT;
            end
            WAIT: begin
                if (cnt == 4'd0)
                    next_state = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Latency counter and request latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= 4'd0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= 3'b000;
        end else if (accept) begin
            cnt      <= 4'(LATENCY - 1);
            we_q     <= req_we;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            funct3_q <= req_funct3;
        end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Response registers, captured once at commit and held through RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (commit) begin
            resp_rdata <= rdata_ext;
            resp_err   <= lane_err;
        end
    end

    // Storage array; contents survive reset, and a reset edge suppresses a pending store.
    always_ff @(posedge clk) begin
        if (!reset && commit) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i])
                    mem[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [8:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_funct3 = 3'b000;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] rd;
    logic        er;
    int          lat;

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request/response transaction; hold > 0 keeps resp_ready low for that many RESP cycles.
    task automatic xact(input logic we, input logic [8:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input int hold,
                        output logic [31:0] rdata, output logic err, output int cycles);
        @(negedge clk);
        check("req_ready_before", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        @(posedge clk);
        cycles = 0;
        @(negedge clk);
        req_valid = 1'b0;
        while (!resp_valid && cycles < 40) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        check("latency", cycles, LAT);
        rdata = resp_rdata;
        err   = resp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", {31'b0, resp_valid}, 32'd1);
            check("hold_rdata", resp_rdata, rdata);
            check("hold_req_ready", {31'b0, req_ready}, 32'd0);
            check("hold_busy", {31'b0, busy}, 32'd1);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check("post_req_ready", {31'b0, req_ready}, 32'd1);
        check("post_resp_valid", {31'b0, resp_valid}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
        check({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
        check({tag, "_resp_rdata"}, resp_rdata, 32'h0);
        check({tag, "_resp_err"}, {31'b0, resp_err}, 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        xact(1'b1, 9'h010, 32'hDEADBEEF, 3'b010, 0, rd, er, lat);
        check("sw_rdata", rd, 32'h0);
        check("sw_err", {31'b0, er}, 32'd0);
        xact(1'b0, 9'h010, 32'h0, 3'b010, 0, rd, er, lat);
        check("lw_010", rd, 32'hDEADBEEF);
        check("lw_010_err", {31'b0, er}, 32'd0);
        xact(1'b0, 9'h013, 32'h0, 3'b000, 0, rd, er, lat);
        check("lb_013", rd, 32'hFFFFFFDE);
        xact(1'b0, 9'h013, 32'h0, 3'b100, 0, rd, er, lat);
        check("lbu_013", rd, 32'h000000DE);
        xact(1'b0, 9'h010, 32'h0, 3'b001, 0, rd, er, lat);
        check("lh_010", rd, 32'hFFFFBEEF);
        xact(1'b0, 9'h012, 32'h0, 3'b101, 0, rd, er, lat);
        check("lhu_012", rd, 32'h0000DEAD);

        xact(1'b1, 9'h011, 32'hAAAAAA55, 3'b000, 0, rd, er, lat);
        xact(1'b0, 9'h010, 32'h0, 3'b010, 0, rd, er, lat);
        check("lw_after_sb", rd, 32'hDEAD55EF);

        xact(1'b0, 9'h010, 32'h0, 3'b010, 5, rd, er, lat);
        check("lw_held", rd, 32'hDEAD55EF);

        xact(1'b0, 9'h012, 32'h0, 3'b010, 0, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("lw_012_rdata", rd, 32'h0);
        check("lw_012_err", {31'b0, er}, 32'd1);
`else
        check("lw_012_rdata", rd, 32'hDEAD55EF);
        check("lw_012_err", {31'b0, er}, 32'd0);
`endif

        xact(1'b0, 9'h010, 32'h0, 3'b011, 0, rd, er, lat);
        check("ld_f3_011_rdata", rd, 32'h0);
        check("ld_f3_011_err", {31'b0, er}, 32'd1);
        xact(1'b1, 9'h010, 32'hFFFFFFFF, 3'b011, 0, rd, er, lat);
        check("st_f3_011_err", {31'b0, er}, 32'd1);
        xact(1'b0, 9'h010, 32'h0, 3'b010, 0, rd, er, lat);
        check("lw_after_bad_store", rd, 32'hDEAD55EF);

        xact(1'b1, 9'h020, 32'h11112222, 3'b010, 0, rd, er, lat);
        // Accept a store, then reset during WAIT so it never commits.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 9'h020;
        req_wdata  = 32'h12345678;
        req_funct3 = 3'b010;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("wait_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("reset_in_wait");
        xact(1'b0, 9'h020, 32'h0, 3'b010, 0, rd, er, lat);
        check("lw_020_after_abort", rd, 32'h11112222);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
